// File: rtl/store_pkg.sv
// Shared definitions for the store unit: store opcodes, FSM states and the
// lane-encoded queue entry format.
package store_pkg;

  typedef enum logic [1:0] {
    OP_SW  = 2'b00,
    OP_SH  = 2'b01,
    OP_SB  = 2'b10,
    OP_ILL = 2'b11
  } st_op_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_e;

  // Entries keep only the word index; the byte offset is folded into be.
  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

endpackage

// File: rtl/store_align.sv
// Store lane encoder: byte enables, replicated write data and the
// misaligned/illegal flag for one store request.
module store_align
  import store_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        err
);

  always_comb begin
    be    = 4'b0000;
    wdata = 32'h0;
    err   = 1'b0;
    case (st_op_e'(op))
      OP_SW: begin
        be    = 4'b1111;
        wdata = data;
        err   = (addr_lo != 2'b00);
      end
      OP_SH: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data[15:0]}};
        err   = addr_lo[0];
      end
      OP_SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{data[7:0]}};
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: lane-encodes MEM-stage stores into a small FIFO and issues
// them to data memory one at a time with a req/ack handshake.
//
// state   | meaning
// S_IDLE  | queue empty, mem_req low
// S_ISSUE | mem_req high, head entry presented until mem_ack
module store_unit
  import store_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        idle
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  entry_t            q_q [DEPTH];
  entry_t            q_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              st_err_q, st_err_d;
  state_e            state_q, state_d;

  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic        al_err;
  logic        hs, push, pop;
  entry_t      new_entry, head;

  store_align u_align (
    .op      (st_op),
    .addr_lo (st_addr[1:0]),
    .data    (st_data),
    .be      (al_be),
    .wdata   (al_wdata),
    .err     (al_err)
  );

  // No bypass: a pop this cycle does not free a slot until the next one.
  assign st_ready = !reset && (cnt_q != CNT_FULL);
  assign hs       = st_valid && st_ready;
  assign push     = hs && !al_err;
  assign pop      = (state_q == S_ISSUE) && mem_ack;

  assign new_entry = '{waddr: st_addr[31:2], wdata: al_wdata, be: al_be};
  assign head      = q_q[rd_ptr_q];

  always_comb begin
    q_d      = q_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    st_err_d = hs && al_err;
    if (push) begin
      q_d[wr_ptr_q] = new_entry;
      wr_ptr_d      = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      st_err_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      st_err_q <= st_err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (push) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (pop && !push && (cnt_q == CNT_ONE)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state_q == S_ISSUE);
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'b0000;
    if (mem_req) begin
      mem_addr  = {head.waddr, 2'b00};
      mem_wdata = head.wdata;
      mem_be    = head.be;
    end
  end

  assign st_err = st_err_q;
  assign idle   = (cnt_q == '0) && !mem_req;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: stimulus queues expected memory writes,
// a negedge monitor pops and compares each write as it is presented.
module tb_store_unit;
  import store_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [1:0]  st_op = 2'b00;
  logic [31:0] st_addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic        st_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic        idle;

  always #5 clk = ~clk;

  store_unit #(.DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_op     (st_op),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_err    (st_err),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .idle      (idle)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
  } vec_t;

  txn_t exp_q[$];
  txn_t cur = '{addr: 32'h0, wdata: 32'h0, be: 4'h0};
  int   total = 0;
  int   bad = 0;
  int   req_cnt = 0;
  int   base;
  logic prev_req = 1'b0;
  logic prev_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; legal ones are queued for the monitor.
  task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                      input bit exp_err, input logic [31:0] ea, input logic [31:0] ew,
                      input logic [3:0] ebe);
    st_op = op;
    st_addr = a;
    st_data = d;
    st_valid = 1'b1;
    chk("ready_before_push", {31'h0, st_ready}, 32'h1);
    if (!exp_err) exp_q.push_back('{addr: ea, wdata: ew, be: ebe});
    tick();
    st_valid = 1'b0;
    chk("st_err_after_push", {31'h0, st_err}, {31'h0, exp_err});
  endtask

  task automatic ack_one();
    for (int i = 0; i < 20 && !mem_req; i++) tick();
    chk("mem_req_before_ack", {31'h0, mem_req}, 32'h1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (mem_req) begin
        req_cnt++;
        if (!prev_req || prev_ack) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got addr %0h with no write expected", mem_addr);
          end else begin
            cur = exp_q.pop_front();
          end
        end
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_wdata", mem_wdata, cur.wdata);
        chk("mem_be", {28'h0, mem_be}, {28'h0, cur.be});
      end else begin
        chk("idle_bus_zero", mem_addr | mem_wdata | {28'h0, mem_be}, 32'h0);
      end
      prev_req = mem_req;
      prev_ack = mem_ack;
    end
  end

  vec_t vecs[6];

  initial begin
    vecs[0] = '{OP_SH, 32'h0000_2002, 32'h1234_CAFE, 32'h0000_2000, 32'hCAFE_CAFE, 4'b1100};
    vecs[1] = '{OP_SH, 32'h0000_2000, 32'h1234_CAFE, 32'h0000_2000, 32'hCAFE_CAFE, 4'b0011};
    vecs[2] = '{OP_SB, 32'h0000_1000, 32'hFFFF_FF55, 32'h0000_1000, 32'h5555_5555, 4'b0001};
    vecs[3] = '{OP_SB, 32'h0000_1001, 32'h0000_0012, 32'h0000_1000, 32'h1212_1212, 4'b0010};
    vecs[4] = '{OP_SB, 32'h0000_1002, 32'h0000_0034, 32'h0000_1000, 32'h3434_3434, 4'b0100};
    vecs[5] = '{OP_SW, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111};

    // Reset values
    tick();
    tick();
    chk("rst_st_ready", {31'h0, st_ready}, 32'h0);
    chk("rst_idle", {31'h0, idle}, 32'h1);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_st_err", {31'h0, st_err}, 32'h0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", {31'h0, st_ready}, 32'h1);
    tick();

    // sb to 0x1003, ack one cycle after mem_req rises
    base = req_cnt;
    push(OP_SB, 32'h0000_1003, 32'h0000_00AB, 1'b0, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000);
    chk("sb_req_rise", {31'h0, mem_req}, 32'h1);
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("sb_req_fall", {31'h0, mem_req}, 32'h0);
    chk("sb_req_cycles", req_cnt - base, 2);
    tick();
    chk("sb_idle", {31'h0, idle}, 32'h1);

    // Lane-encoding table
    foreach (vecs[i]) begin
      push(vecs[i].op, vecs[i].addr, vecs[i].data, 1'b0,
           vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_be);
      ack_one();
    end
    tick();

    // Misaligned and illegal requests
    base = req_cnt;
    push(OP_SW, 32'h0000_3001, 32'h1111_1111, 1'b1, 32'h0, 32'h0, 4'h0);
    chk("err_sw_idle", {31'h0, idle}, 32'h1);
    tick();
    chk("err_sw_pulse_end", {31'h0, st_err}, 32'h0);
    push(OP_SH, 32'h0000_3003, 32'h2222_2222, 1'b1, 32'h0, 32'h0, 4'h0);
    tick();
    chk("err_sh_pulse_end", {31'h0, st_err}, 32'h0);
    push(OP_ILL, 32'h0000_3000, 32'h3333_3333, 1'b1, 32'h0, 32'h0, 4'h0);
    tick();
    chk("err_ill_pulse_end", {31'h0, st_err}, 32'h0);
    chk("err_no_req", req_cnt - base, 0);
    chk("err_idle", {31'h0, idle}, 32'h1);

    // Fill DEPTH=2 with ack held low, third store waits for space
    st_op = OP_SW;
    st_addr = 32'h0000_4000;
    st_data = 32'h1111_1111;
    st_valid = 1'b1;
    exp_q.push_back('{addr: 32'h0000_4000, wdata: 32'h1111_1111, be: 4'b1111});
    tick();
    chk("full_req_rise", {31'h0, mem_req}, 32'h1);
    chk("full_ready_1", {31'h0, st_ready}, 32'h1);
    st_addr = 32'h0000_4004;
    st_data = 32'h2222_2222;
    exp_q.push_back('{addr: 32'h0000_4004, wdata: 32'h2222_2222, be: 4'b1111});
    tick();
    chk("full_ready_0", {31'h0, st_ready}, 32'h0);
    st_addr = 32'h0000_4008;
    st_data = 32'h3333_3333;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_hold_ready", {31'h0, st_ready}, 32'h0);
      chk("full_hold_addr", mem_addr, 32'h0000_4000);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("full_ready_back", {31'h0, st_ready}, 32'h1);
    exp_q.push_back('{addr: 32'h0000_4008, wdata: 32'h3333_3333, be: 4'b1111});
    tick();
    st_valid = 1'b0;
    chk("full_second_addr", mem_addr, 32'h0000_4004);
    ack_one();
    ack_one();
    tick();
    chk("full_drained_idle", {31'h0, idle}, 32'h1);
    chk("full_drained_ready", {31'h0, st_ready}, 32'h1);

    // Reset with two stores pending
    push(OP_SW, 32'h0000_5000, 32'hAAAA_0000, 1'b0, 32'h0000_5000, 32'hAAAA_0000, 4'b1111);
    push(OP_SW, 32'h0000_5004, 32'hBBBB_0000, 1'b0, 32'h0000_5004, 32'hBBBB_0000, 4'b1111);
    chk("pre_rst_full", {31'h0, st_ready}, 32'h0);
    reset = 1'b1;
    #1;
    chk("mid_rst_req", {31'h0, mem_req}, 32'h0);
    chk("mid_rst_idle", {31'h0, idle}, 32'h1);
    chk("mid_rst_ready", {31'h0, st_ready}, 32'h0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    base = req_cnt;
    mem_ack = 1'b1;
    tick();
    tick();
    mem_ack = 1'b0;
    tick();
    chk("post_rst_req", {31'h0, mem_req}, 32'h0);
    chk("post_rst_idle", {31'h0, idle}, 32'h1);
    chk("post_rst_no_issue", req_cnt - base, 0);
    chk("post_rst_ready", {31'h0, st_ready}, 32'h1);

    tick();
    chk("expected_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
